// File: rtl/coinc_readout.sv
// Read-out end of the coincidence path: snapshots the pair counters once per
// integration window and streams them as an XOR-checksummed byte frame.
module coinc_readout #(
   parameter  int NCHAN  = 4,
   parameter  int CWIDTH = 16,
   parameter  int WINDOW = 1000000,
   localparam int NPAIR  = NCHAN * (NCHAN - 1) / 2
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      Enable,
   input  logic [NPAIR*CWIDTH-1:0]   Counts,
   output logic                      CountClr,
   output logic [7:0]                TxData,
   output logic                      TxValid,
   input  logic                      TxReady,
   output logic                      Overrun,
   output logic [7:0]                Seq
);

   localparam int BPC    = CWIDTH / 8;
   localparam int NBYTES = NPAIR * BPC;
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TW     = $clog2(WINDOW);
   localparam logic [7:0] HDR_BYTE = 8'hA5;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_DATA, S_CSUM} state_t;

   state_t                   state_q, state_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic [7:0]               seq_q, seq_d;
   logic [7:0]               frame_seq_q, frame_seq_d;
   logic [7:0]               csum_q, csum_d;
   logic [BW-1:0]            idx_q, idx_d;
   logic [NBYTES-1:0][7:0]   shadow_q, shadow_d;
   logic [NBYTES-1:0][7:0]   load_bytes;
   logic                     terminal;
   logic                     accept;

   // Shadow byte order is transmit order: pair 0 first, MSB byte first.
   for (genvar p = 0; p < NPAIR; p++) begin : g_pair
      for (genvar k = 0; k < BPC; k++) begin : g_byte
         assign load_bytes[p*BPC + k] = Counts[p*CWIDTH + CWIDTH - 8 - 8*k +: 8];
      end
   end

   // Handshake: a byte moves on any cycle with TxValid & TxReady; while
   // TxValid is high and TxReady low, TxData and TxValid hold unchanged.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      seq_d       = seq_q;
      frame_seq_d = frame_seq_q;
      csum_d      = csum_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      TxData      = 8'h00;

      terminal = Enable && (timer_q == TW'(WINDOW - 1));
      TxValid  = (state_q != S_IDLE);
      accept   = TxValid && TxReady;
      CountClr = terminal;
      Overrun  = terminal && (state_q != S_IDLE);

      if (!Enable || terminal) timer_d = '0;
      else                     timer_d = timer_q + TW'(1);
      if (terminal) seq_d = seq_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (terminal) begin
               state_d     = S_HDR;
               shadow_d    = load_bytes;
               frame_seq_d = seq_q;
               idx_d       = '0;
            end
         end
         S_HDR: begin
            TxData = HDR_BYTE;
            if (accept) state_d = S_SEQ;
         end
         S_SEQ: begin
            TxData = frame_seq_q;
            if (accept) state_d = S_DATA;
         end
         S_DATA: begin
            TxData = shadow_q[idx_q];
            if (accept) begin
               if (idx_q == BW'(NBYTES - 1)) state_d = S_CSUM;
               else                          idx_d   = idx_q + BW'(1);
            end
         end
         S_CSUM: begin
            TxData = csum_q;
            if (accept) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // The accumulator restarts with every snapshot; the checksum byte itself
      // is never folded in because the frame ends on its acceptance.
      if (state_q == S_IDLE) begin
         if (terminal) csum_d = 8'h00;
      end else if (accept) begin
         csum_d = csum_q ^ TxData;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         seq_q       <= 8'h00;
         frame_seq_q <= 8'h00;
         csum_q      <= 8'h00;
         idx_q       <= '0;
         shadow_q    <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         seq_q       <= seq_d;
         frame_seq_q <= frame_seq_d;
         csum_q      <= csum_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
      end
   end

   assign Seq = seq_q;

endmodule

// File: tb/tb_coinc_readout.sv
// Bench for coinc_readout: two instances (WINDOW=8 and WINDOW=32) share one
// stimulus stream and are checked every cycle against a frame-queue model.
module tb_coinc_readout;

   localparam int W0   = 8;
   localparam int W1   = 32;
   localparam int FLEN = 15;
   localparam int NB   = 96;

   logic          Clk = 1'b0;
   logic          Rst, Enable, TxReady;
   logic [NB-1:0] Counts;
   logic [1:0]      cc, txv, ov;
   logic [1:0][7:0] txd, sq;

   always #5 Clk = ~Clk;

   coinc_readout #(.WINDOW(W0)) d8 (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .Counts(Counts),
      .CountClr(cc[0]), .TxData(txd[0]), .TxValid(txv[0]), .TxReady(TxReady),
      .Overrun(ov[0]), .Seq(sq[0])
   );

   coinc_readout #(.WINDOW(W1)) d32 (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .Counts(Counts),
      .CountClr(cc[1]), .TxData(txd[1]), .TxValid(txv[1]), .TxReady(TxReady),
      .Overrun(ov[1]), .Seq(sq[1])
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] exp_q[$];
   logic [7:0] cap0[$];
   logic [7:0] cap1[$];

   // Model: a pending-frame byte list per instance; empty means idle.
   logic [7:0] m_frame [2][FLEN];
   int         m_ptr   [2] = '{FLEN, FLEN};
   int         m_timer [2] = '{0, 0};
   logic [7:0] m_seq   [2] = '{8'h00, 8'h00};
   int         m_cyc   [2] = '{0, 0};
   bit         m_on = 1'b0;

   int first_cc [2] = '{-1, -1};
   int first_ov [2] = '{-1, -1};
   int first_v  [2] = '{-1, -1};
   int cc_cnt   [2] = '{0, 0};
   int ov_cnt   [2] = '{0, 0};

   function automatic int win(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   function automatic void check(input string name, input int inst, input int cyc,
                                 input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s inst=%0d cyc=%0d: got %0h expected %0h", name, inst, cyc, act, exp);
      end
   endfunction

   function automatic int cap_byte(input int inst, input int k);
      if (inst == 0) return (k < cap0.size()) ? int'(cap0[k]) : -1;
      return (k < cap1.size()) ? int'(cap1[k]) : -1;
   endfunction

   function automatic int cap_size(input int inst);
      return (inst == 0) ? cap0.size() : cap1.size();
   endfunction

   // Hand-written frame with only pair 0 non-zero.
   task automatic push_frame(input logic [7:0] seq, input logic [15:0] pair0,
                             input logic [7:0] csum);
      exp_q.push_back(8'hA5);
      exp_q.push_back(seq);
      exp_q.push_back(pair0[15:8]);
      exp_q.push_back(pair0[7:0]);
      for (int k = 0; k < 10; k++) exp_q.push_back(8'h00);
      exp_q.push_back(csum);
   endtask

   task automatic compare_exp(input string name, input int inst, input int base);
      for (int k = 0; k < exp_q.size(); k++)
         check(name, inst, base + k, cap_byte(inst, base + k), int'(exp_q[k]));
      exp_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk) begin
      for (int i = 0; i < 2; i++) begin
         bit         busy;
         bit         e_cc;
         logic [7:0] cs;
         busy = (m_ptr[i] < FLEN);
         e_cc = Enable && (m_timer[i] == win(i) - 1);
         if (m_on) begin
            check("CountClr", i, m_cyc[i], int'(cc[i]), int'(e_cc));
            check("Overrun", i, m_cyc[i], int'(ov[i]), int'(e_cc && busy));
            check("TxValid", i, m_cyc[i], int'(txv[i]), int'(busy));
            check("Seq", i, m_cyc[i], int'(sq[i]), int'(m_seq[i]));
            if (busy) check("TxData", i, m_cyc[i], int'(txd[i]), int'(m_frame[i][m_ptr[i]]));
            if (cc[i]) begin
               cc_cnt[i]++;
               if (first_cc[i] < 0) first_cc[i] = m_cyc[i];
            end
            if (ov[i]) begin
               ov_cnt[i]++;
               if (first_ov[i] < 0) first_ov[i] = m_cyc[i];
            end
            if (txv[i] && first_v[i] < 0) first_v[i] = m_cyc[i];
            if (txv[i] && TxReady) begin
               if (i == 0) cap0.push_back(txd[i]);
               else        cap1.push_back(txd[i]);
            end
         end
         if (Rst) begin
            m_timer[i]  = 0;
            m_seq[i]    = 8'h00;
            m_ptr[i]    = FLEN;
            m_cyc[i]    = 0;
            first_cc[i] = -1;
            first_ov[i] = -1;
            first_v[i]  = -1;
            cc_cnt[i]   = 0;
            ov_cnt[i]   = 0;
            if (i == 0) cap0.delete();
            else        cap1.delete();
         end else begin
            if (busy && TxReady) m_ptr[i]++;
            if (e_cc) begin
               if (!busy) begin
                  m_frame[i][0] = 8'hA5;
                  m_frame[i][1] = m_seq[i];
                  for (int p = 0; p < 6; p++) begin
                     m_frame[i][2 + 2*p] = Counts[p*16 + 8 +: 8];
                     m_frame[i][3 + 2*p] = Counts[p*16 +: 8];
                  end
                  cs = 8'h00;
                  for (int k = 0; k < FLEN - 1; k++) cs = cs ^ m_frame[i][k];
                  m_frame[i][FLEN-1] = cs;
                  m_ptr[i] = 0;
               end
               m_seq[i] = m_seq[i] + 8'd1;
            end
            m_timer[i] = (!Enable || e_cc) ? 0 : m_timer[i] + 1;
            m_cyc[i]++;
         end
      end
      if (Rst) m_on = 1'b1;
   end

   initial begin
      Rst     = 1'b1;
      Enable  = 1'b1;
      TxReady = 1'b1;
      Counts  = '0;
      tick(3);
      Rst = 1'b0;

      // All-zero frame on d8, field ordering on d32 (pair0 set before its first snapshot).
      tick(25);
      Counts = 96'h1234;
      tick(60);
      check("t1 first CountClr", 0, 85, first_cc[0], 7);
      check("t1 first TxValid", 0, 85, first_v[0], 8);
      check("t1 first Overrun", 0, 85, first_ov[0], 15);
      push_frame(8'h00, 16'h0000, 8'hA5);
      compare_exp("t1 zero frame", 0, 0);
      check("t1 frame2 hdr", 0, 85, cap_byte(0, 15), 8'hA5);
      check("t1 frame2 seq", 0, 85, cap_byte(0, 16), 8'h02);
      check("t2 first CountClr", 1, 85, first_cc[1], 31);
      push_frame(8'h00, 16'h1234, 8'h83);
      compare_exp("t2 frame seq0", 1, 0);
      push_frame(8'h01, 16'h1234, 8'h82);
      compare_exp("t2 frame seq1", 1, 15);

      // Backpressure: ready one cycle in three, counts changing.
      for (int k = 0; k < 180; k++) begin
         TxReady = (k % 3 == 0);
         if (k % 12 == 0) Counts = {$urandom, $urandom, $urandom};
         tick(1);
      end

      // Overrun while the sink is stalled.
      Rst = 1'b1; TxReady = 1'b0; Counts = 96'h5;
      tick(1);
      Rst = 1'b0;
      tick(40);
      TxReady = 1'b1;
      tick(18);
      check("t4 overrun count", 0, 58, ov_cnt[0], 5);
      check("t4 frame1 seq", 0, 58, cap_byte(0, 1), 8'h00);
      check("t4 frame2 seq", 0, 58, cap_byte(0, 16), 8'h06);
      check("t4 Seq port", 0, 58, int'(sq[0]), 7);

      // Enable gating, then Enable dropped while frames are in flight.
      Rst = 1'b1; Enable = 1'b0; Counts = 96'hFF;
      tick(1);
      Rst = 1'b0;
      tick(50);
      check("t5 no CountClr d8", 0, 50, cc_cnt[0], 0);
      check("t5 no CountClr d32", 1, 50, cc_cnt[1], 0);
      check("t5 no bytes d8", 0, 50, cap_size(0), 0);
      check("t5 no bytes d32", 1, 50, cap_size(1), 0);
      Enable = 1'b1;
      tick(35);
      Enable = 1'b0;
      tick(25);
      check("t5 re-enable CountClr d8", 0, 110, first_cc[0], 57);
      check("t5 re-enable CountClr d32", 1, 110, first_cc[1], 81);
      check("t5 byte count d8", 0, 110, cap_size(0), 30);
      check("t5 byte count d32", 1, 110, cap_size(1), 15);
      push_frame(8'h00, 16'h00FF, 8'h5A);
      compare_exp("t5 frame d32", 1, 0);
      push_frame(8'h02, 16'h00FF, 8'h58);
      compare_exp("t5 frame2 d8", 0, 15);
      check("t5 Seq d8", 0, 110, int'(sq[0]), 4);
      check("t5 Seq d32", 1, 110, int'(sq[1]), 1);

      // Reset pulsed while d8 is in DATA.
      Rst = 1'b1; Enable = 1'b1; TxReady = 1'b1; Counts = 96'h5;
      tick(1);
      Rst = 1'b0;
      tick(12);
      check("t6 in flight", 0, 12, int'(txv[0]), 1);
      Rst = 1'b1;
      tick(1);
      Rst = 1'b0;
      @(negedge Clk);
      check("t6 TxValid after reset", 0, 0, int'(txv[0]), 0);
      check("t6 Seq after reset", 0, 0, int'(sq[0]), 0);
      tick(20);
      check("t6 first CountClr", 0, 20, first_cc[0], 7);
      check("t6 first TxValid", 0, 20, first_v[0], 8);
      check("t6 header", 0, 20, cap_byte(0, 0), 8'hA5);
      check("t6 seq byte", 0, 20, cap_byte(0, 1), 8'h00);
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
